// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared types and constants for the branch/hazard controller: FSM states,
// forwarding-select encodings, counter width and a register-match helper.
package branch_hazard_ctrl_pkg;

    localparam int CNT_W = 16;
    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_e;

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic             wr_en,
                                       input logic [REG_W-1:0] dest,
                                       input logic [REG_W-1:0] src);
        return wr_en && (dest != '0) && (dest == src);
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// Operand forwarding select for the ID instruction. MEM (the instruction now in
// EX) has priority over WB (a registered copy of the MEM-stage destination).
module forwarding_unit
    import branch_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             ex_wb_en,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] mem_dest,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b
);

    logic             wb_en_q, wb_en_d;
    logic [REG_W-1:0] wb_dest_q, wb_dest_d;
    fwd_sel_e         sel_a, sel_b;

    // The WB copy must not advance while the whole pipe is frozen.
    always_comb begin
        wb_en_d   = wb_en_q;
        wb_dest_d = wb_dest_q;
        if (!hold) begin
            wb_en_d   = mem_wb_en;
            wb_dest_d = mem_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_dest_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_dest_q <= wb_dest_d;
        end
    end

    always_comb begin
        sel_a = FWD_RF;
        if (reg_match(ex_wb_en, ex_dest, id_src1)) begin
            sel_a = FWD_MEM;
        end else if (reg_match(wb_en_q, wb_dest_q, id_src1)) begin
            sel_a = FWD_WB;
        end
        sel_b = FWD_RF;
        if (id_two_src) begin
            if (reg_match(ex_wb_en, ex_dest, id_src2)) begin
                sel_b = FWD_MEM;
            end else if (reg_match(wb_en_q, wb_dest_q, id_src2)) begin
                sel_b = FWD_WB;
            end
        end
    end

    assign fwd_sel_a = sel_a;
    assign fwd_sel_b = sel_b;

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Pipeline hazard/branch controller: RAW stalls, taken-branch flush, SRAM wait
// freeze and saturating event counters. Define FORWARDING_EN for forwarding.
module branch_hazard_ctrl
    import branch_hazard_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_branch_taken,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_two_src,
    input  logic             ex_wb_en,
    input  logic             ex_mem_read,
    input  logic             mem_wb_en,
    input  logic [REG_W-1:0] ex_dest,
    input  logic [REG_W-1:0] mem_dest,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_freeze,
    output logic             ifid_freeze,
    output logic             idex_bubble,
    output logic             flush,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`ifdef FORWARDING_EN
    ,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b
`endif
);

    state_e           state_q, state_d;
    logic             pending_q, pending_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             hazard;
    logic             stall;
    logic             flush_int;
    logic             freeze_int;

`ifdef FORWARDING_EN
    // With forwarding only a load result still in EX forces a stall.
    assign hazard = reg_match(ex_mem_read, ex_dest, id_src1) |
                    (id_two_src & reg_match(ex_mem_read, ex_dest, id_src2));

    forwarding_unit u_forwarding_unit (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (freeze_int),
        .id_src1    (id_src1),
        .id_src2    (id_src2),
        .id_two_src (id_two_src),
        .ex_wb_en   (ex_wb_en),
        .ex_dest    (ex_dest),
        .mem_wb_en  (mem_wb_en),
        .mem_dest   (mem_dest),
        .fwd_sel_a  (fwd_sel_a),
        .fwd_sel_b  (fwd_sel_b)
    );
`else
    // A load in EX writes back too, so it counts as an EX writer.
    logic ex_writes;
    assign ex_writes = ex_wb_en | ex_mem_read;
    assign hazard = reg_match(ex_writes, ex_dest, id_src1) |
                    reg_match(mem_wb_en, mem_dest, id_src1) |
                    (id_two_src & (reg_match(ex_writes, ex_dest, id_src2) |
                                   reg_match(mem_wb_en, mem_dest, id_src2)));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pending_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // A branch resolving while the SRAM stalls is remembered until the exit.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    state_d   = ST_MEM_WAIT;
                    pending_d = ex_branch_taken;
                end else if (ex_branch_taken) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    pending_d = pending_q | ex_branch_taken;
                end else begin
                    state_d   = (pending_q | ex_branch_taken) ? ST_FLUSH : ST_RUN;
                    pending_d = 1'b0;
                end
            end
            ST_FLUSH: begin
                state_d   = mem_busy ? ST_MEM_WAIT : ST_RUN;
                pending_d = 1'b0;
            end
            default: begin
                state_d   = ST_RUN;
                pending_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        flush_int  = 1'b0;
        stall      = 1'b0;
        freeze_int = mem_busy;
        unique case (state_q)
            ST_RUN: begin
                flush_int = ex_branch_taken & ~mem_busy;
                stall     = hazard & ~ex_branch_taken & ~mem_busy;
            end
            ST_MEM_WAIT: begin
                flush_int = ~mem_busy & (pending_q | ex_branch_taken);
                stall     = ~mem_busy & hazard & ~(pending_q | ex_branch_taken);
            end
            ST_FLUSH: begin
                flush_int = 1'b0;
                stall     = 1'b0;
            end
            default: begin
                flush_int = 1'b0;
                stall     = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if ((stall | freeze_int) && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush_int && (flush_cnt_q != '1)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    assign flush       = flush_int;
    assign pipe_freeze = freeze_int;
    assign idex_bubble = stall;
    assign pc_freeze   = freeze_int | stall;
    assign ifid_freeze = freeze_int | stall;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl; expectations follow the FORWARDING_EN
// setting of the build.
module tb_branch_hazard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_branch_taken;
    logic [4:0]  id_src1, id_src2;
    logic        id_two_src;
    logic        ex_wb_en, ex_mem_read, mem_wb_en;
    logic [4:0]  ex_dest, mem_dest;
    logic        mem_busy;
    logic        cnt_clr;
    logic        pc_freeze, ifid_freeze, idex_bubble, flush, pipe_freeze;
    logic [15:0] stall_cnt, flush_cnt;
`ifdef FORWARDING_EN
    logic [1:0]  fwd_sel_a, fwd_sel_b;
`endif

    int total = 0;
    int bad   = 0;

    branch_hazard_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ex_branch_taken (ex_branch_taken),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_two_src      (id_two_src),
        .ex_wb_en        (ex_wb_en),
        .ex_mem_read     (ex_mem_read),
        .mem_wb_en       (mem_wb_en),
        .ex_dest         (ex_dest),
        .mem_dest        (mem_dest),
        .mem_busy        (mem_busy),
        .cnt_clr         (cnt_clr),
        .pc_freeze       (pc_freeze),
        .ifid_freeze     (ifid_freeze),
        .idex_bubble     (idex_bubble),
        .flush           (flush),
        .pipe_freeze     (pipe_freeze),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`ifdef FORWARDING_EN
        ,
        .fwd_sel_a       (fwd_sel_a),
        .fwd_sel_b       (fwd_sel_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        ex_branch_taken = 1'b0;
        id_src1 = '0; id_src2 = '0; id_two_src = 1'b0;
        ex_wb_en = 1'b0; ex_mem_read = 1'b0; mem_wb_en = 1'b0;
        ex_dest = '0; mem_dest = '0;
        mem_busy = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic clear_counters();
        clr_in();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        // Reset state
        clr_in();
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_pipe_freeze", 32'(pipe_freeze), 32'h0);
        tick();
        rst_n = 1'b1;

        // RAW on src1 from EX (not a load)
        ex_wb_en = 1'b1; ex_dest = 5'd5; id_src1 = 5'd5;
        @(negedge clk);
`ifdef FORWARDING_EN
        chk("raw_ex_bubble", 32'(idex_bubble), 32'h0);
        chk("raw_ex_pc_freeze", 32'(pc_freeze), 32'h0);
        chk("raw_ex_fwd_a", 32'(fwd_sel_a), 32'h1);
`else
        chk("raw_ex_bubble", 32'(idex_bubble), 32'h1);
        chk("raw_ex_pc_freeze", 32'(pc_freeze), 32'h1);
        chk("raw_ex_ifid_freeze", 32'(ifid_freeze), 32'h1);
`endif
        tick();
        clr_in();
        @(negedge clk);
`ifdef FORWARDING_EN
        chk("raw_ex_stall_cnt", 32'(stall_cnt), 32'h0);
`else
        chk("raw_ex_stall_cnt", 32'(stall_cnt), 32'h1);
`endif

        // Destination register 0 never matches
        ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd0; id_src1 = 5'd0;
        @(negedge clk);
        chk("r0_bubble", 32'(idex_bubble), 32'h0);
`ifdef FORWARDING_EN
        chk("r0_fwd_a", 32'(fwd_sel_a), 32'h0);
`endif
        tick();
        clr_in();

        // MEM writer vs src2: ignored unless id_two_src
        mem_wb_en = 1'b1; mem_dest = 5'd7; id_src2 = 5'd7; id_src1 = 5'd1;
        @(negedge clk);
        chk("src2_unused_bubble", 32'(idex_bubble), 32'h0);
        tick();
        id_two_src = 1'b1;
        @(negedge clk);
`ifdef FORWARDING_EN
        chk("src2_used_bubble", 32'(idex_bubble), 32'h0);
        chk("src2_fwd_b_wb", 32'(fwd_sel_b), 32'h2);
`else
        chk("src2_used_bubble", 32'(idex_bubble), 32'h1);
`endif
        tick();
        clr_in();

        // Load-use stalls in every build
        ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd3; id_src1 = 5'd3;
        @(negedge clk);
        chk("load_use_bubble", 32'(idex_bubble), 32'h1);
        tick();

        // Taken branch with a hazard present: flush wins, then one FLUSH cycle
        clear_counters();
        ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd3; id_src1 = 5'd3;
        ex_branch_taken = 1'b1;
        @(negedge clk);
        chk("br_flush", 32'(flush), 32'h1);
        chk("br_bubble", 32'(idex_bubble), 32'h0);
        chk("br_pc_freeze", 32'(pc_freeze), 32'h0);
        tick();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        chk("flush_state_flush", 32'(flush), 32'h0);
        chk("flush_state_bubble", 32'(idex_bubble), 32'h0);
        chk("br_flush_cnt", 32'(flush_cnt), 32'h1);
        tick();
        @(negedge clk);
        chk("after_flush_bubble", 32'(idex_bubble), 32'h1);
        chk("after_flush_stall_cnt", 32'(stall_cnt), 32'h0);
        tick();
        clr_in();

        // SRAM wait 3 cycles, branch resolves in cycle 2
        clear_counters();
        mem_busy = 1'b1;
        @(negedge clk);
        chk("mw1_pipe_freeze", 32'(pipe_freeze), 32'h1);
        chk("mw1_pc_freeze", 32'(pc_freeze), 32'h1);
        chk("mw1_flush", 32'(flush), 32'h0);
        tick();
        ex_branch_taken = 1'b1;
        @(negedge clk);
        chk("mw2_pipe_freeze", 32'(pipe_freeze), 32'h1);
        chk("mw2_ifid_freeze", 32'(ifid_freeze), 32'h1);
        chk("mw2_flush", 32'(flush), 32'h0);
        tick();
        ex_branch_taken = 1'b0;
        @(negedge clk);
        chk("mw3_pipe_freeze", 32'(pipe_freeze), 32'h1);
        chk("mw3_flush", 32'(flush), 32'h0);
        tick();
        mem_busy = 1'b0;
        @(negedge clk);
        chk("mw_exit_pipe_freeze", 32'(pipe_freeze), 32'h0);
        chk("mw_exit_flush", 32'(flush), 32'h1);
        tick();
        @(negedge clk);
        chk("mw_post_flush", 32'(flush), 32'h0);
        chk("mw_stall_cnt", 32'(stall_cnt), 32'h3);
        chk("mw_flush_cnt", 32'(flush_cnt), 32'h1);
        tick();

        // Reset in the middle of MEM_WAIT with a pending branch
        mem_busy = 1'b1; ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall_cnt", 32'(stall_cnt), 32'h0);
        chk("mid_rst_flush_cnt", 32'(flush_cnt), 32'h0);
        mem_busy = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_flush", 32'(flush), 32'h0);
        chk("post_rst_pipe_freeze", 32'(pipe_freeze), 32'h0);
        tick();
        ex_wb_en = 1'b1; ex_mem_read = 1'b1; ex_dest = 5'd9; id_src1 = 5'd9;
        @(negedge clk);
        chk("post_rst_flush2", 32'(flush), 32'h0);
        chk("post_rst_run_bubble", 32'(idex_bubble), 32'h1);
        chk("post_rst_flush_cnt", 32'(flush_cnt), 32'h0);

        // Saturation: 70000 stall cycles
        repeat (70000) tick();
        @(negedge clk);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        tick();
        @(negedge clk);
        chk("sat_hold_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        @(negedge clk);
        chk("clr_wins_stall_cnt", 32'(stall_cnt), 32'h0);
        tick();
        @(negedge clk);
        chk("after_clr_stall_cnt", 32'(stall_cnt), 32'h1);
        clr_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
